// File: rtl/tlb_op_unit.sv
// CP0-side TLB maintenance sequencer: TLBP/TLBR/TLBWI/TLBWR.
// Owns the Random register and returns CP0 updates after each op.
`ifndef TLB_ENTRIES_NUM
`define TLB_ENTRIES_NUM 16
`endif

package tlb_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } tlb_op_e;
endpackage

module tlb_op_unit
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = `TLB_ENTRIES_NUM,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  output logic             req_ready,
  output logic             done,
  input  logic [31:0]      cp0_index,
  input  logic [31:0]      cp0_wired,
  input  logic [31:0]      cp0_entry_hi,
  input  logic [31:0]      cp0_entry_lo0,
  input  logic [31:0]      cp0_entry_lo1,
  input  logic             wired_we,
  output logic [31:0]      random,
  output logic [IDX_W-1:0] tlbrw_index,
  output logic             tlbrw_we,
  output tlb_entry_t       tlbrw_wdata,
  input  tlb_entry_t       tlbrw_rdata,
  output logic [31:0]      tlbp_entry_hi,
  input  logic [31:0]      tlbp_index,
  output logic             upd_index_we,
  output logic [31:0]      upd_index,
  output logic             upd_entry_we,
  output logic [31:0]      upd_entry_hi,
  output logic [31:0]      upd_entry_lo0,
  output logic [31:0]      upd_entry_lo1,
  output logic             tlb_flush
);

  localparam logic [IDX_W-1:0] RND_MAX =
    IDX_W'(TLB_ENTRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e           state;
  tlb_op_e          op_q;
  logic [IDX_W-1:0] rnd_q;
  tlb_entry_t       wr_ent;
  logic             unused;

  assign unused = ^{cp0_index[31:IDX_W],
                    cp0_entry_hi[12:8],
                    cp0_entry_lo0[31:26],
                    cp0_entry_lo1[31:26]};

  assign random = 32'(rnd_q);

  always_comb begin
    wr_ent      = '0;
    wr_ent.vpn2 = cp0_entry_hi[31:13];
    wr_ent.asid = cp0_entry_hi[7:0];
    wr_ent.g    = cp0_entry_lo0[0] & cp0_entry_lo1[0];
    wr_ent.pfn0 = cp0_entry_lo0[25:6];
    wr_ent.c0   = cp0_entry_lo0[5:3];
    wr_ent.d0   = cp0_entry_lo0[2];
    wr_ent.v0   = cp0_entry_lo0[1];
    wr_ent.pfn1 = cp0_entry_lo1[25:6];
    wr_ent.c1   = cp0_entry_lo1[5:3];
    wr_ent.d1   = cp0_entry_lo1[2];
    wr_ent.v1   = cp0_entry_lo1[1];
  end

  // Wired above the top entry also lands here: random <= wired always.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q <= RND_MAX;
    end else if (wired_we || (32'(rnd_q) <= cp0_wired)) begin
      rnd_q <= RND_MAX;
    end else begin
      rnd_q <= rnd_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      op_q          <= OP_TLBP;
      req_ready     <= 1'b1;
      done          <= 1'b0;
      tlbrw_index   <= '0;
      tlbrw_we      <= 1'b0;
      tlbrw_wdata   <= '0;
      tlbp_entry_hi <= '0;
      upd_index_we  <= 1'b0;
      upd_index     <= '0;
      upd_entry_we  <= 1'b0;
      upd_entry_hi  <= '0;
      upd_entry_lo0 <= '0;
      upd_entry_lo1 <= '0;
      tlb_flush     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            state         <= S_ISSUE;
            op_q          <= tlb_op_e'(req_op);
            req_ready     <= 1'b0;
            tlbrw_index   <= (req_op == OP_TLBWR) ?
                             rnd_q : cp0_index[IDX_W-1:0];
            tlbrw_we      <= req_op[1];
            tlbrw_wdata   <= wr_ent;
            tlbp_entry_hi <= cp0_entry_hi;
          end
        end
        S_ISSUE: begin
          state    <= S_CAPTURE;
          tlbrw_we <= 1'b0;
        end
        S_CAPTURE: begin
          state <= S_RESP;
          done  <= 1'b1;
          unique case (1'b1)
            (op_q == OP_TLBP): begin
              upd_index_we <= 1'b1;
              upd_index    <= tlbp_index;
            end
            (op_q == OP_TLBR): begin
              upd_entry_we  <= 1'b1;
              upd_entry_hi  <= {tlbrw_rdata.vpn2, 5'b0,
                                tlbrw_rdata.asid};
              upd_entry_lo0 <= {6'b0, tlbrw_rdata.pfn0,
                                tlbrw_rdata.c0, tlbrw_rdata.d0,
                                tlbrw_rdata.v0, tlbrw_rdata.g};
              upd_entry_lo1 <= {6'b0, tlbrw_rdata.pfn1,
                                tlbrw_rdata.c1, tlbrw_rdata.d1,
                                tlbrw_rdata.v1, tlbrw_rdata.g};
            end
            default: tlb_flush <= 1'b1;
          endcase
        end
        S_RESP: begin
          state         <= S_IDLE;
          req_ready     <= 1'b1;
          done          <= 1'b0;
          tlbrw_index   <= '0;
          tlbrw_wdata   <= '0;
          tlbp_entry_hi <= '0;
          upd_index_we  <= 1'b0;
          upd_index     <= '0;
          upd_entry_we  <= 1'b0;
          upd_entry_hi  <= '0;
          upd_entry_lo0 <= '0;
          upd_entry_lo1 <= '0;
          tlb_flush     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit with a 16-entry TLB model.
// Table vectors for single ops, hand sequences for timing corners.
module tb_tlb_op_unit;
  import tlb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic        req_ready;
  logic        done;
  logic [31:0] cp0_index, cp0_wired, cp0_entry_hi;
  logic [31:0] cp0_entry_lo0, cp0_entry_lo1;
  logic        wired_we;
  logic [31:0] random;
  logic [3:0]  tlbrw_index;
  logic        tlbrw_we;
  tlb_entry_t  tlbrw_wdata, tlbrw_rdata;
  logic [31:0] tlbp_entry_hi, tlbp_index;
  logic        upd_index_we, upd_entry_we, tlb_flush;
  logic [31:0] upd_index, upd_entry_hi;
  logic [31:0] upd_entry_lo0, upd_entry_lo1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlb_op_unit #(.TLB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .done(done),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired),
    .cp0_entry_hi(cp0_entry_hi),
    .cp0_entry_lo0(cp0_entry_lo0),
    .cp0_entry_lo1(cp0_entry_lo1),
    .wired_we(wired_we), .random(random),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we),
    .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata),
    .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .upd_index_we(upd_index_we), .upd_index(upd_index),
    .upd_entry_we(upd_entry_we),
    .upd_entry_hi(upd_entry_hi),
    .upd_entry_lo0(upd_entry_lo0),
    .upd_entry_lo1(upd_entry_lo1),
    .tlb_flush(tlb_flush)
  );

  tlb_entry_t tlb [16];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tlb[i] <= '0;
    end else if (tlbrw_we) begin
      tlb[tlbrw_index] <= tlbrw_wdata;
    end
  end

  assign tlbrw_rdata = tlb[tlbrw_index];

  always_comb begin
    tlbp_index = 32'h8000_0000;
    for (int i = 15; i >= 0; i--) begin
      if (tlb[i].vpn2 == tlbp_entry_hi[31:13] &&
          (tlb[i].g || tlb[i].asid == tlbp_entry_hi[7:0]))
        tlbp_index = 32'(i);
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] idx, hi, lo0, lo1;
    logic [3:0]  e_idx;
    logic        e_we, e_flush, e_iwe;
    logic [31:0] e_index;
    logic        e_ewe;
    logic [31:0] e_hi, e_lo0, e_lo1;
  } vec_t;

  vec_t vecs [11];
  vec_t wr;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    wired_we = 1'b0;
    tick();
    tick();
    chk("rst_random", random, 32'd15);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(tlbrw_we), 32'd0);
    chk("rst_flush", 32'(tlb_flush), 32'd0);
    chk("rst_idx", 32'(tlbrw_index), 32'd0);
    chk("rst_upd", 32'({upd_index_we, upd_entry_we}), 32'd0);
    rst = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op = v.op;
    cp0_index = v.idx;
    cp0_entry_hi = v.hi;
    cp0_entry_lo0 = v.lo0;
    cp0_entry_lo1 = v.lo1;
    tick();
    req_valid = 1'b0;
    cp0_index = 32'h0000_000A;
    cp0_entry_hi = 32'hDEAD_BEEF;
    cp0_entry_lo0 = 32'hFFFF_FFFF;
    cp0_entry_lo1 = 32'hFFFF_FFFF;
    chk("issue_we", 32'(tlbrw_we), 32'(v.e_we));
    chk("issue_idx", 32'(tlbrw_index), 32'(v.e_idx));
    chk("issue_hi", tlbp_entry_hi, v.hi);
    chk("issue_ready", 32'(req_ready), 32'd0);
    if (v.e_we) begin
      chk("wd_vpn2", 32'(tlbrw_wdata.vpn2), 32'(v.hi[31:13]));
      chk("wd_asid", 32'(tlbrw_wdata.asid), 32'(v.hi[7:0]));
      chk("wd_g", 32'(tlbrw_wdata.g), 32'(v.lo0[0] & v.lo1[0]));
      chk("wd_pfn0", 32'(tlbrw_wdata.pfn0), 32'(v.lo0[25:6]));
      chk("wd_pfn1", 32'(tlbrw_wdata.pfn1), 32'(v.lo1[25:6]));
    end
    tick();
    chk("cap_we", 32'(tlbrw_we), 32'd0);
    chk("cap_done", 32'(done), 32'd0);
    chk("cap_idx", 32'(tlbrw_index), 32'(v.e_idx));
    tick();
    chk("resp_done", 32'(done), 32'd1);
    chk("resp_flush", 32'(tlb_flush), 32'(v.e_flush));
    chk("resp_iwe", 32'(upd_index_we), 32'(v.e_iwe));
    chk("resp_ewe", 32'(upd_entry_we), 32'(v.e_ewe));
    if (v.e_iwe) chk("resp_index", upd_index, v.e_index);
    if (v.e_ewe) begin
      chk("resp_hi", upd_entry_hi, v.e_hi);
      chk("resp_lo0", upd_entry_lo0, v.e_lo0);
      chk("resp_lo1", upd_entry_lo1, v.e_lo1);
    end
    tick();
    chk("post_done", 32'(done), 32'd0);
    chk("post_flush", 32'(tlb_flush), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_upd", 32'({upd_index_we, upd_entry_we}), 32'd0);
    chk("post_idx", 32'(tlbrw_index), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'd2, 32'd5, 32'h0040_2012, 32'h41F, 32'h45F,
                4'd5, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0,
                32'd0, 32'd0, 32'd0};
    vecs[1] = '{2'd1, 32'd5, 32'h1234_5678, 32'd0, 32'd0,
                4'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1,
                32'h0040_2012, 32'h41F, 32'h45F};
    vecs[2] = '{2'd0, 32'd0, 32'h0040_2012, 32'd0, 32'd0,
                4'd0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0,
                32'd0, 32'd0, 32'd0};
    vecs[3] = '{2'd0, 32'd0, 32'h0040_2034, 32'd0, 32'd0,
                4'd0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0,
                32'd0, 32'd0, 32'd0};
    vecs[4] = '{2'd2, 32'd5, 32'h0040_2012, 32'h41E, 32'h45F,
                4'd5, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0,
                32'd0, 32'd0, 32'd0};
    vecs[5] = '{2'd0, 32'd0, 32'h0040_2034, 32'd0, 32'd0,
                4'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0,
                32'd0, 32'd0, 32'd0};
    vecs[6] = '{2'd0, 32'd0, 32'h0040_2012, 32'd0, 32'd0,
                4'd0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0,
                32'd0, 32'd0, 32'd0};
    vecs[7] = '{2'd1, 32'd5, 32'd0, 32'd0, 32'd0,
                4'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1,
                32'h0040_2012, 32'h41E, 32'h45E};
    vecs[8] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h03FF_FFFF, 32'd0,
                4'd15, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0,
                32'd0, 32'd0, 32'd0};
    vecs[9] = '{2'd1, 32'd15, 32'd0, 32'd0, 32'd0,
                4'd15, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1,
                32'hFFFF_E0FF, 32'h03FF_FFFE, 32'd0};
    vecs[10] = '{2'd0, 32'd0, 32'hFFFF_E0FF, 32'd0, 32'd0,
                 4'd0, 1'b0, 1'b0, 1'b1, 32'd15, 1'b0,
                 32'd0, 32'd0, 32'd0};

    req_op = 2'd0;
    cp0_index = '0;
    cp0_wired = '0;
    cp0_entry_hi = '0;
    cp0_entry_lo0 = '0;
    cp0_entry_lo1 = '0;
    do_reset();

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // TLBWR: three idle cycles after reset leave random at 12
    do_reset();
    tick();
    tick();
    tick();
    chk("wr_random", random, 32'd12);
    wr = '{2'd3, 32'd2, 32'h0080_4056, 32'h007, 32'h00F,
           4'd12, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0,
           32'd0, 32'd0, 32'd0};
    run_op(wr);
    wr = '{2'd1, 32'd12, 32'd0, 32'd0, 32'd0,
           4'd12, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1,
           32'h0080_4056, 32'h007, 32'h00F};
    run_op(wr);

    // back-to-back: valid held high
    req_valid = 1'b1;
    req_op = 2'd0;
    cp0_entry_hi = 32'h0080_4056;
    for (int i = 0; i < 12; i++) begin
      chk("bb_ready", 32'(req_ready), 32'((i % 4) == 0));
      chk("bb_done", 32'(done), 32'((i % 4) == 3));
      tick();
    end
    req_valid = 1'b0;
    chk("bb_idle", 32'(req_ready), 32'd1);

    // reset during CAPTURE of a TLBWI
    req_valid = 1'b1;
    req_op = 2'd2;
    cp0_index = 32'd3;
    tick();
    req_valid = 1'b0;
    chk("ab_we", 32'(tlbrw_we), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ab_done", 32'(done), 32'd0);
      chk("ab_flush", 32'(tlb_flush), 32'd0);
      chk("ab_ready", 32'(req_ready), 32'd1);
      chk("ab_we0", 32'(tlbrw_we), 32'd0);
      tick();
    end

    // Random with wired=4
    cp0_wired = 32'd4;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("rnd_seq", random, 32'((i <= 11) ? 15 - i : 27 - i));
      tick();
    end
    chk("rnd_pre", random, 32'd11);
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    chk("rnd_wired_we", random, 32'd15);
    tick();
    chk("rnd_after_we", random, 32'd14);
    cp0_wired = 32'd20;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rnd_big_wired", random, 32'd15);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
